// File: rtl/pipe_in_driver.sv
// ---------------------------------------------------------------------------
// pipe_in_driver
//
// Generates test-pattern blocks for a downstream sink. A run begins with a
// start pulse. For each block the driver waits for the sink to declare that
// it can take a whole block. It then pulses block_strobe and streams
// BLOCK_LEN words. A rotating 32-bit throttle pattern gates individual
// write cycles. Words come either from a 32-bit LFSR (low half shown) or
// from a 16-bit counter.
//
// Optional feature macro: PIPE_IN_DRIVER_STATS_EN
//   defined   -> words_sent is a saturating count of writes since start
//   undefined -> words_sent is tied to zero
//
// Parameters
//   BLOCK_LEN     words per block (power of 2, 2..1024)
//
// Ports
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse that begins a run (ignored while busy)
//   stop          abort, back to IDLE at the next edge
//   mode          data source: 0 = LFSR, 1 = counter (sampled on start)
//   block_count   blocks per run, 0 = continuous (sampled on start)
//   throttle_set  load throttle_val into the throttle register
//   throttle_val  write-enable pattern, bit 0 gates the current cycle
//   sink_ready    sink can accept a full block (sampled only in WAIT_RDY)
//   write         data valid and consumed this cycle
//   data          payload word, meaningful when write = 1
//   block_strobe  one-cycle pulse just before each block's first XFER cycle
//   busy          high in every state except IDLE
//   done          one-cycle pulse after the final block of a run
//   words_sent    words written since start (see macro above)
// ---------------------------------------------------------------------------
module pipe_in_driver #(
  parameter int BLOCK_LEN = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic [15:0] block_count,
  input  logic        throttle_set,
  input  logic [31:0] throttle_val,
  input  logic        sink_ready,
  output logic        write,
  output logic [15:0] data,
  output logic        block_strobe,
  output logic        busy,
  output logic        done,
  output logic [31:0] words_sent
);

  localparam int          CW   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [31:0] SEED = 32'h0D0C_0B0A;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    STROBE   = 3'd2,
    XFER     = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [31:0]   throttle, throttle_n;
  logic [31:0]   lfsr, lfsr_n;
  logic [15:0]   cnt, cnt_n;
  logic [15:0]   blocks_left, blocks_left_n;
  logic [CW-1:0] word_cnt, word_cnt_n;
  logic          src_mode, src_mode_n;
  logic          continuous, continuous_n;
  logic          write_n, strobe_n, busy_n, done_n;
  logic [15:0]   data_n;
  logic          start_ok;
  logic          block_end;

  // Next-state and next-output logic. Every output register is loaded from
  // the value that the corresponding state-derived expression will have after
  // the edge. This keeps all outputs registered but lets them line up with the
  // state they describe.
  // The write register therefore always equals (state == XFER && throttle[0]).
  // The logic below relies on that: it uses "write" as "a word is being
  // consumed this cycle".
  always_comb begin
    state_n       = state;
    throttle_n    = throttle;
    lfsr_n        = lfsr;
    cnt_n         = cnt;
    blocks_left_n = blocks_left;
    word_cnt_n    = word_cnt;
    src_mode_n    = src_mode;
    continuous_n  = continuous;
    data_n        = data;

    start_ok  = (state == IDLE) && start && !stop;
    block_end = write && (word_cnt == CW'(BLOCK_LEN - 1));

    case (state)
      IDLE: begin
        if (start) begin
          state_n       = WAIT_RDY;
          blocks_left_n = block_count;
          continuous_n  = (block_count == 16'd0);
          src_mode_n    = mode;
          lfsr_n        = SEED;
          cnt_n         = 16'd1;
          word_cnt_n    = '0;
        end
      end
      WAIT_RDY: begin
        if (sink_ready) begin
          state_n = STROBE;
        end
      end
      STROBE: begin
        state_n = XFER;
      end
      XFER: begin
        if (block_end) begin
          blocks_left_n = blocks_left - 16'd1;
          if (!continuous && (blocks_left == 16'd1)) begin
            state_n = DONE;
          end else begin
            state_n = WAIT_RDY;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // The source and per-block word count advance only on consumed words.
    // word_cnt wraps back to zero at the end of a block because BLOCK_LEN is
    // a power of two.
    if (write) begin
      word_cnt_n = word_cnt + 1'b1;
      if (src_mode) begin
        cnt_n = cnt + 16'd1;
      end else begin
        lfsr_n = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
      end
    end

    // Rotation runs on every XFER cycle. A software load overrides it.
    if (state == XFER) begin
      throttle_n = {throttle[0], throttle[31:1]};
    end
    if (throttle_set) begin
      throttle_n = throttle_val;
    end

    if (stop) begin
      state_n = IDLE;
    end

    write_n  = (state_n == XFER) && throttle_n[0];
    strobe_n = (state_n == STROBE);
    busy_n   = (state_n != IDLE);
    done_n   = (state_n == DONE);

    // data shows the word being consumed and holds otherwise.
    if (write_n) begin
      data_n = src_mode_n ? cnt_n : lfsr_n[15:0];
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      throttle     <= 32'hFFFF_FFFF;
      lfsr         <= SEED;
      cnt          <= '0;
      blocks_left  <= '0;
      word_cnt     <= '0;
      src_mode     <= 1'b0;
      continuous   <= 1'b0;
      write        <= 1'b0;
      data         <= '0;
      block_strobe <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      throttle     <= throttle_n;
      lfsr         <= lfsr_n;
      cnt          <= cnt_n;
      blocks_left  <= blocks_left_n;
      word_cnt     <= word_cnt_n;
      src_mode     <= src_mode_n;
      continuous   <= continuous_n;
      write        <= write_n;
      data         <= data_n;
      block_strobe <= strobe_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

`ifdef PIPE_IN_DRIVER_STATS_EN
  logic [31:0] words_cnt;

  // Saturating count of consumed words, restarted by an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      words_cnt <= '0;
    end else if (start_ok) begin
      words_cnt <= '0;
    end else if (write && (words_cnt != 32'hFFFF_FFFF)) begin
      words_cnt <= words_cnt + 32'd1;
    end
  end

  assign words_sent = words_cnt;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign words_sent      = '0;
`endif

endmodule

// File: tb/tb_pipe_in_driver.sv
// ---------------------------------------------------------------------------
// tb_pipe_in_driver
//
// Self-checking bench for pipe_in_driver with BLOCK_LEN = 4. A passive
// monitor records every consumed word, block strobes, done pulses and the
// per-cycle write pattern inside each block. Scenario tasks compare these
// records against a reference model. The model gives the k-th source word
// for each mode and the throttle bit that applies to the k-th XFER cycle
// of a run.
// ---------------------------------------------------------------------------
module tb_pipe_in_driver;

  localparam int          BL    = 4;
  localparam int          LIMIT = 2000;
  localparam logic [31:0] SEED  = 32'h0D0C_0B0A;
`ifdef PIPE_IN_DRIVER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] block_count = '0;
  logic        throttle_set = 1'b0;
  logic [31:0] throttle_val = '0;
  logic        sink_ready = 1'b0;
  logic        write;
  logic [15:0] data;
  logic        block_strobe;
  logic        busy;
  logic        done;
  logic [31:0] words_sent;

  int checks = 0;
  int failures = 0;

  // monitor records
  logic [15:0] got_q[$];
  logic        pat_q[$];
  int          strobe_cnt = 0;
  int          done_cnt = 0;
  int          hold_viol = 0;

  pipe_in_driver #(.BLOCK_LEN(BL)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .stop         (stop),
    .mode         (mode),
    .block_count  (block_count),
    .throttle_set (throttle_set),
    .throttle_val (throttle_val),
    .sink_ready   (sink_ready),
    .write        (write),
    .data         (data),
    .block_strobe (block_strobe),
    .busy         (busy),
    .done         (done),
    .words_sent   (words_sent)
  );

  always #5 clk = ~clk;

  // Passive monitor, sampling on the falling edge. After a strobe, the cycles
  // up to the BL-th write of the block are the XFER cycles.
  initial begin : monitor
    bit          in_xfer;
    int          blk_writes;
    logic [15:0] prev_data;
    in_xfer    = 1'b0;
    blk_writes = 0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (write === 1'b1) got_q.push_back(data);
      if (block_strobe === 1'b1) strobe_cnt++;
      if (done === 1'b1) done_cnt++;
      if (in_xfer) begin
        pat_q.push_back(write);
        if (write !== 1'b1 && data !== prev_data) hold_viol++;
        if (write === 1'b1) blk_writes++;
        if (blk_writes == BL) in_xfer = 1'b0;
      end
      if (block_strobe === 1'b1) begin
        in_xfer    = 1'b1;
        blk_writes = 0;
      end
      if (busy !== 1'b1) in_xfer = 1'b0;
      prev_data = data;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // k-th word (0-based) of a run in the given mode
  function automatic logic [15:0] exp_word(input logic m, input int k);
    logic [31:0] s;
    if (m) return 16'(k + 1);
    s = SEED;
    for (int i = 0; i < k; i++) s = lfsr_step(s);
    return s[15:0];
  endfunction

  // number of XFER cycles needed for n writes under throttle pattern p
  function automatic int exp_xfer_cycles(input logic [31:0] p, input int n);
    int ones;
    int k;
    ones = 0;
    k = 0;
    while (ones < n) begin
      if (p[k % 32]) ones++;
      k++;
    end
    return k;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_throttle(input logic [31:0] v);
    throttle_val = v;
    throttle_set = 1'b1;
    cyc();
    throttle_set = 1'b0;
  endtask

  task automatic pulse_start(input logic m, input logic [15:0] bc);
    mode        = m;
    block_count = bc;
    start       = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Waits for a done pulse. With rnd set, sink_ready, mode and start are
  // scrambled while the run is busy.
  task automatic wait_done(input bit rnd, output bit ok);
    int base;
    base = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      cyc();
      if (done_cnt > base) begin
        ok = 1'b1;
        break;
      end
      if (rnd) begin
        sink_ready = 1'($urandom_range(0, 1));
        mode       = 1'($urandom_range(0, 1));
        start      = ($urandom_range(0, 3) == 0);
      end
    end
    start      = 1'b0;
    sink_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL reset_write: got %b want 0", write); end
    checks++; if (block_strobe !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobe: got %b want 0", block_strobe); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data: got %h want 0000", data); end
    checks++; if (words_sent !== 32'd0) begin failures++; $display("[TB] FAIL reset_words: got %0d want 0", words_sent); end
    reset_n = 1'b1;
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_counter_run();
    int gb, sb, db, pb, hb, bad;
    bit ok;
    sink_ready = 1'b1;
    set_throttle(32'hFFFF_FFFF);
    gb = got_q.size(); sb = strobe_cnt; db = done_cnt; pb = pat_q.size(); hb = hold_viol;
    pulse_start(1'b1, 16'd2);
    // mid-run mode change and start pulse must be ignored
    mode  = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL cnt_timeout: no done within %0d cycles", LIMIT); end
    checks++; if (got_q.size() - gb !== 8) begin failures++; $display("[TB] FAIL cnt_words: got %0d want 8", got_q.size() - gb); end
    bad = 0;
    for (int k = 0; k < 8 && gb + k < got_q.size(); k++)
      if (got_q[gb + k] !== exp_word(1'b1, k)) bad++;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL cnt_data: %0d wrong words, want 1..8", bad); end
    checks++; if (strobe_cnt - sb !== 2) begin failures++; $display("[TB] FAIL cnt_strobes: got %0d want 2", strobe_cnt - sb); end
    checks++; if (done_cnt - db !== 1) begin failures++; $display("[TB] FAIL cnt_done: got %0d want 1", done_cnt - db); end
    checks++; if (words_sent !== (STATS ? 32'd8 : 32'd0)) begin failures++; $display("[TB] FAIL cnt_words_sent: got %0d want %0d", words_sent, STATS ? 8 : 0); end
    bad = 0;
    for (int k = pb; k < pat_q.size(); k++) if (pat_q[k] !== 1'b1) bad++;
    checks++; if (bad != 0 || pat_q.size() - pb != 8) begin failures++; $display("[TB] FAIL cnt_pattern: %0d gaps over %0d cycles want 0 over 8", bad, pat_q.size() - pb); end
    checks++; if (hold_viol !== hb) begin failures++; $display("[TB] FAIL cnt_hold: got %0d want %0d", hold_viol, hb); end
    cyc();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL cnt_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_lfsr_run();
    int gb, bad;
    bit ok;
    sink_ready = 1'b1;
    set_throttle(32'hFFFF_FFFF);
    gb = got_q.size();
    pulse_start(1'b0, 16'd1);
    wait_done(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL lfsr_timeout: no done"); end
    checks++; if (got_q.size() - gb !== 4) begin failures++; $display("[TB] FAIL lfsr_words: got %0d want 4", got_q.size() - gb); end
    if (got_q.size() > gb) begin
      checks++; if (got_q[gb] !== 16'h0B0A) begin failures++; $display("[TB] FAIL lfsr_first: got %h want 0b0a", got_q[gb]); end
    end
    bad = 0;
    for (int k = 0; k < 4 && gb + k < got_q.size(); k++)
      if (got_q[gb + k] !== exp_word(1'b0, k)) bad++;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL lfsr_data: %0d words differ from model", bad); end
    cyc();
  endtask

  task automatic test_throttle();
    int gb, pb, hb, bad;
    bit ok;
    logic [31:0] p;
    p = 32'h5555_5555;
    sink_ready = 1'b1;
    set_throttle(p);
    gb = got_q.size(); pb = pat_q.size(); hb = hold_viol;
    pulse_start(1'b1, 16'd1);
    wait_done(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL thr_timeout: no done"); end
    bad = 0;
    for (int k = pb; k < pat_q.size(); k++) if (pat_q[k] !== p[(k - pb) % 32]) bad++;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL thr_pattern: %0d cycles off the 1,0 alternation", bad); end
    checks++; if (pat_q.size() - pb !== exp_xfer_cycles(p, BL)) begin failures++; $display("[TB] FAIL thr_cycles: got %0d want %0d", pat_q.size() - pb, exp_xfer_cycles(p, BL)); end
    checks++; if (hold_viol !== hb) begin failures++; $display("[TB] FAIL thr_hold: data changed on %0d idle cycles", hold_viol - hb); end
    bad = 0;
    for (int k = 0; k < 4 && gb + k < got_q.size(); k++)
      if (got_q[gb + k] !== exp_word(1'b1, k)) bad++;
    checks++; if (bad != 0 || got_q.size() - gb != 4) begin failures++; $display("[TB] FAIL thr_data: %0d bad of %0d want 0 of 4", bad, got_q.size() - gb); end
    cyc();
  endtask

  task automatic test_wait_ready();
    int viol, gb, bad;
    bit ok;
    set_throttle(32'hFFFF_FFFF);
    sink_ready = 1'b0;
    gb = got_q.size();
    pulse_start(1'b1, 16'd1);
    viol = 0;
    for (int i = 0; i < 50; i++) begin
      if (block_strobe !== 1'b0 || write !== 1'b0 || busy !== 1'b1) viol++;
      cyc();
    end
    checks++; if (viol != 0) begin failures++; $display("[TB] FAIL wait_stall: %0d bad cycles while sink not ready", viol); end
    sink_ready = 1'b1;
    wait_done(1'b0, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL wait_timeout: no done"); end
    bad = 0;
    for (int k = 0; k < 4 && gb + k < got_q.size(); k++)
      if (got_q[gb + k] !== exp_word(1'b1, k)) bad++;
    checks++; if (bad != 0 || got_q.size() - gb != 4) begin failures++; $display("[TB] FAIL wait_data: %0d bad of %0d want 0 of 4", bad, got_q.size() - gb); end
    cyc();
  endtask

  task automatic test_stop_continuous();
    int gb, sb, db, viol, bad;
    bit ok;
    sink_ready = 1'b1;
    set_throttle(32'hFFFF_FFFF);
    gb = got_q.size(); sb = strobe_cnt; db = done_cnt;
    pulse_start(1'b1, 16'd0);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      if (strobe_cnt - sb >= 3) begin ok = 1'b1; break; end
      cyc();
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL stop_timeout: third block never strobed"); end
    cyc();  // first XFER cycle of the third block, a word is consumed
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL stop_write: got %b want 0", write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL stop_busy: got %b want 0", busy); end
    checks++; if (got_q.size() - gb !== 9) begin failures++; $display("[TB] FAIL stop_words: got %0d want 9", got_q.size() - gb); end
    bad = 0;
    for (int k = 0; k < 9 && gb + k < got_q.size(); k++)
      if (got_q[gb + k] !== exp_word(1'b1, k)) bad++;
    checks++; if (bad != 0) begin failures++; $display("[TB] FAIL stop_data: %0d wrong words", bad); end
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (write !== 1'b0 || busy !== 1'b0 || block_strobe !== 1'b0) viol++;
      cyc();
    end
    checks++; if (viol != 0) begin failures++; $display("[TB] FAIL stop_quiet: %0d active cycles after stop", viol); end
    checks++; if (done_cnt !== db) begin failures++; $display("[TB] FAIL stop_done: got %0d pulses want 0", done_cnt - db); end
  endtask

  task automatic test_stop_start();
    int viol;
    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      if (busy !== 1'b0) viol++;
      cyc();
    end
    checks++; if (viol != 0) begin failures++; $display("[TB] FAIL stop_start_busy: busy on %0d cycles want 0", viol); end
  endtask

  task automatic test_reset_mid_xfer();
    int gb, gb2, pb, viol, bad;
    bit ok;
    sink_ready = 1'b1;
    set_throttle(32'hFFFF_FFFF);
    gb = got_q.size();
    pulse_start(1'b1, 16'd2);
    ok = 1'b0;
    for (int i = 0; i < LIMIT; i++) begin
      if (got_q.size() - gb >= 2) begin ok = 1'b1; break; end
      cyc();
    end
    checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rst_timeout: no writes seen"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (write !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_write: got %b want 0", write); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_busy: got %b want 0", busy); end
    checks++; if (data !== 16'h0000) begin failures++; $display("[TB] FAIL rst_async_data: got %h want 0000", data); end
    checks++; if (words_sent !== 32'd0 || block_strobe !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_misc: words %0d strobe %b done %b want 0", words_sent, block_strobe, done); end
    cyc();
    cyc();
    reset_n = 1'b1;
    gb2 = got_q.size();
    viol = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0) viol++;
      cyc();
    end
    checks++; if (viol != 0 || got_q.size() != gb2) begin failures++; $display("[TB] FAIL rst_abandon: busy %0d cycles, %0d writes want 0", viol, got_q.size() - gb2); end
    // throttle must be back to all ones: run without reloading it
    gb = got_q.size(); pb = pat_q.size();
    pulse_start(1'b1, 16'd1);
    wait_done(1'b0, ok);
    bad = 0;
    for (int k = 0; k < 4 && gb + k < got_q.size(); k++)
      if (got_q[gb + k] !== exp_word(1'b1, k)) bad++;
    checks++; if (!ok || bad != 0 || got_q.size() - gb != 4 || pat_q.size() - pb != 4) begin failures++; $display("[TB] FAIL rst_rerun: ok %b bad %0d words %0d cycles %0d want 1 0 4 4", ok, bad, got_q.size() - gb, pat_q.size() - pb); end
    cyc();
  endtask

  task automatic test_random_runs();
    int gb, sb, db, pb, hb, n, bad;
    bit ok;
    logic m;
    logic [15:0] bc;
    logic [31:0] p;
    for (int r = 0; r < 6; r++) begin
      m  = 1'($urandom_range(0, 1));
      bc = 16'($urandom_range(1, 3));
      p  = $urandom | 32'h1;
      n  = int'(bc) * BL;
      set_throttle(p);
      gb = got_q.size(); sb = strobe_cnt; db = done_cnt; pb = pat_q.size(); hb = hold_viol;
      pulse_start(m, bc);
      wait_done(1'b1, ok);
      mode = 1'b0;
      checks++; if (ok !== 1'b1) begin failures++; $display("[TB] FAIL rnd%0d_timeout: no done", r); end
      bad = 0;
      for (int k = 0; k < n && gb + k < got_q.size(); k++)
        if (got_q[gb + k] !== exp_word(m, k)) bad++;
      checks++; if (bad != 0 || got_q.size() - gb != n) begin failures++; $display("[TB] FAIL rnd%0d_data: %0d bad of %0d want 0 of %0d (mode %b)", r, bad, got_q.size() - gb, n, m); end
      checks++; if (strobe_cnt - sb !== int'(bc)) begin failures++; $display("[TB] FAIL rnd%0d_strobes: got %0d want %0d", r, strobe_cnt - sb, bc); end
      checks++; if (done_cnt - db !== 1) begin failures++; $display("[TB] FAIL rnd%0d_done: got %0d want 1", r, done_cnt - db); end
      bad = 0;
      for (int k = pb; k < pat_q.size(); k++) if (pat_q[k] !== p[(k - pb) % 32]) bad++;
      checks++; if (bad != 0 || pat_q.size() - pb != exp_xfer_cycles(p, n)) begin failures++; $display("[TB] FAIL rnd%0d_pattern: %0d off over %0d cycles want 0 over %0d (p=%h)", r, bad, pat_q.size() - pb, exp_xfer_cycles(p, n), p); end
      checks++; if (hold_viol !== hb) begin failures++; $display("[TB] FAIL rnd%0d_hold: %0d changes on idle cycles", r, hold_viol - hb); end
      checks++; if (words_sent !== (STATS ? 32'(n) : 32'd0)) begin failures++; $display("[TB] FAIL rnd%0d_words_sent: got %0d want %0d", r, words_sent, STATS ? n : 0); end
      cyc();
      checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rnd%0d_busy_end: got %b want 0", r, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_counter_run();
    test_lfsr_run();
    test_throttle();
    test_wait_ready();
    test_stop_continuous();
    test_stop_start();
    test_reset_mid_xfer();
    test_random_runs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
